// File: rtl/modadd_pkg.sv
// Shared types for the modular adder/subtractor datapath: the per-bit half-adder
// result that the prefix/carry stages consume, and the default slice count.
package modadd_pkg;

  localparam int HAL_WIDTH_DEFAULT = 1;

  typedef struct packed {
    logic a;
    logic not_a;
    logic b;
    logic not_b;
  } hal_bit_t;

  localparam hal_bit_t HAL_BIT_RESET = '{a: 1'b0, not_a: 1'b1, b: 1'b0, not_b: 1'b1};

  function automatic hal_bit_t hal_eval(input logic x, input logic y);
    hal_bit_t res;
    res.a     = x & y;
    res.not_a = ~(x & y);
    res.b     = x ^ y;
    res.not_b = ~(x ^ y);
    return res;
  endfunction

endpackage

// File: rtl/hal_bit.sv
// One combinational half-adder slice: generate and propagate terms
// together with their complements.
module hal_bit
  import modadd_pkg::*;
(
  input  logic     x,
  input  logic     y,
  output hal_bit_t res
);

  assign res = hal_eval(x, y);

endmodule

// File: rtl/hal.sv
// Registered half-adder cell array: WIDTH independent hal_bit slices feeding
// output registers that load on in_valid and hold otherwise.
module hal
  import modadd_pkg::*;
#(
  parameter int WIDTH = HAL_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             out_valid,
  output logic [WIDTH-1:0] not_b,
  output logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] not_a,
  output logic [WIDTH-1:0] a
);

  hal_bit_t         w_slice [WIDTH];
  logic [WIDTH-1:0] w_a;
  logic [WIDTH-1:0] w_not_a;
  logic [WIDTH-1:0] w_b;
  logic [WIDTH-1:0] w_not_b;

  for (genvar i = 0; i < WIDTH; i++) begin : g_slice
    hal_bit u_bit (
      .x   (x[i]),
      .y   (y[i]),
      .res (w_slice[i])
    );
    assign w_a[i]     = w_slice[i].a;
    assign w_not_a[i] = w_slice[i].not_a;
    assign w_b[i]     = w_slice[i].b;
    assign w_not_b[i] = w_slice[i].not_b;
  end

  logic             r_valid;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_not_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_not_b;

  // Complement registers reset to ones so not_x == ~x holds even in reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_a     <= {WIDTH{HAL_BIT_RESET.a}};
      r_not_a <= {WIDTH{HAL_BIT_RESET.not_a}};
      r_b     <= {WIDTH{HAL_BIT_RESET.b}};
      r_not_b <= {WIDTH{HAL_BIT_RESET.not_b}};
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      r_valid <= in_valid;
      if (in_valid) begin
        r_a     <= w_a;
        r_not_a <= w_not_a;
        r_b     <= w_b;
        r_not_b <= w_not_b;
      end
    end
  end

  assign out_valid = r_valid;
  assign a         = r_a;
  assign not_a     = r_not_a;
  assign b         = r_b;
  assign not_b     = r_not_b;

endmodule

// File: tb/tb_hal.sv
// Self-checking bench for hal at WIDTH 1, 4 and 8 driven in lockstep; expected
// results are queued when stimulus is driven and compared one cycle later.
module tb_hal;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] x8;
  logic [7:0] y8;

  logic       ov1, ov4, ov8;
  logic [0:0] a1, na1, b1, nb1;
  logic [3:0] a4, na4, b4, nb4;
  logic [7:0] a8, na8, b8, nb8;

  hal #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .x(x8[0:0]), .y(y8[0:0]),
    .out_valid(ov1), .not_b(nb1), .b(b1), .not_a(na1), .a(a1)
  );

  hal #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .x(x8[3:0]), .y(y8[3:0]),
    .out_valid(ov4), .not_b(nb4), .b(b4), .not_a(na4), .a(a4)
  );

  hal #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .x(x8), .y(y8),
    .out_valid(ov8), .not_b(nb8), .b(b8), .not_a(na8), .a(a8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] x;
    logic [7:0] y;
    logic [7:0] a;
    logic [7:0] b;
  } vec_t;

  typedef struct {
    logic       valid;
    logic [7:0] a;
    logic [7:0] b;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] hold_a;
  logic [7:0] hold_b;
  int         checks;
  int         errors;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, " a8"},  a8,  8'h00);
    check({tag, " b8"},  b8,  8'h00);
    check({tag, " na8"}, na8, 8'hFF);
    check({tag, " nb8"}, nb8, 8'hFF);
    check({tag, " ov8"}, {7'd0, ov8}, 8'h00);
    check({tag, " a4"},  {4'd0, a4},  8'h00);
    check({tag, " na4"}, {4'd0, na4}, 8'h0F);
    check({tag, " nb4"}, {4'd0, nb4}, 8'h0F);
    check({tag, " a1"},  {7'd0, a1},  8'h00);
    check({tag, " b1"},  {7'd0, b1},  8'h00);
    check({tag, " na1"}, {7'd0, na1}, 8'h01);
    check({tag, " nb1"}, {7'd0, nb1}, 8'h01);
    check({tag, " ov1"}, {7'd0, ov1}, 8'h00);
  endtask

  task automatic check_out(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: scoreboard empty at %0t", tag, $time);
      return;
    end
    e = sb.pop_front();
    check({tag, " ov8"}, {7'd0, ov8}, {7'd0, e.valid});
    check({tag, " a8"},  a8,  e.a);
    check({tag, " b8"},  b8,  e.b);
    check({tag, " na8"}, na8, ~e.a);
    check({tag, " nb8"}, nb8, ~e.b);
    check({tag, " ov4"}, {7'd0, ov4}, {7'd0, e.valid});
    check({tag, " a4"},  {4'd0, a4},  {4'd0, e.a[3:0]});
    check({tag, " b4"},  {4'd0, b4},  {4'd0, e.b[3:0]});
    check({tag, " na4"}, {4'd0, na4}, {4'd0, ~e.a[3:0]});
    check({tag, " nb4"}, {4'd0, nb4}, {4'd0, ~e.b[3:0]});
    check({tag, " ov1"}, {7'd0, ov1}, {7'd0, e.valid});
    check({tag, " a1"},  {7'd0, a1},  {7'd0, e.a[0]});
    check({tag, " b1"},  {7'd0, b1},  {7'd0, e.b[0]});
    check({tag, " na1"}, {7'd0, na1}, {7'd0, ~e.a[0]});
    check({tag, " nb1"}, {7'd0, nb1}, {7'd0, ~e.b[0]});
  endtask

  // Called between a negedge and the next posedge: drive, queue, then check.
  task automatic cycle(input string tag, input logic v, input logic [7:0] xx,
                       input logic [7:0] yy, input logic [7:0] ea, input logic [7:0] eb);
    exp_t e;
    in_valid = v;
    x8       = xx;
    y8       = yy;
    if (v) begin
      hold_a = ea;
      hold_b = eb;
    end
    e.valid = v;
    e.a     = hold_a;
    e.b     = hold_b;
    sb.push_back(e);
    @(negedge clk);
    check_out(tag);
  endtask

  vec_t vecs[6];

  initial begin
    logic [7:0] rx, ry;
    logic       rv;
    checks = 0;
    errors = 0;
    hold_a = 8'h00;
    hold_b = 8'h00;

    vecs[0] = '{x: 8'h00, y: 8'h00, a: 8'h00, b: 8'h00};
    vecs[1] = '{x: 8'h00, y: 8'hFF, a: 8'h00, b: 8'hFF};
    vecs[2] = '{x: 8'hFF, y: 8'h00, a: 8'h00, b: 8'hFF};
    vecs[3] = '{x: 8'hFF, y: 8'hFF, a: 8'hFF, b: 8'h00};
    vecs[4] = '{x: 8'hCC, y: 8'hAA, a: 8'h88, b: 8'h66};
    vecs[5] = '{x: 8'hA5, y: 8'h3C, a: 8'h24, b: 8'h99};

    // Reset held with valid all-ones inputs and the clock running.
    rst_n    = 1'b0;
    in_valid = 1'b1;
    x8       = 8'hFF;
    y8       = 8'hFF;
    repeat (3) @(negedge clk);
    check_reset("reset_hold");

    // Mid-cycle release: nothing changes until the next rising edge.
    #2 rst_n = 1'b1;
    #1 check_reset("reset_release");
    cycle("first_after_release", 1'b1, 8'hFF, 8'hFF, 8'hFF, 8'h00);

    for (int i = 0; i < 6; i++)
      cycle($sformatf("vec%0d", i), 1'b1, vecs[i].x, vecs[i].y, vecs[i].a, vecs[i].b);

    // Hold: last valid was 11, then invalid inputs must not disturb outputs.
    cycle("hold_prime", 1'b1, 8'hFF, 8'hFF, 8'hFF, 8'h00);
    cycle("hold1", 1'b0, 8'h00, 8'hFF, 8'h00, 8'h00);
    cycle("hold2", 1'b0, 8'h5A, 8'h33, 8'h00, 8'h00);
    cycle("resume", 1'b1, 8'h0F, 8'h3C, 8'h0C, 8'h33);

    // Mid-stream reset with an in-flight valid input.
    for (int i = 0; i < 5; i++) begin
      rx = 8'($urandom);
      ry = 8'($urandom);
      cycle("pre_reset", 1'b1, rx, ry, rx & ry, rx ^ ry);
    end
    in_valid = 1'b1;
    x8       = 8'hFF;
    y8       = 8'hFF;
    #2 rst_n = 1'b0;
    #1 check_reset("midreset_async");
    sb.delete();
    hold_a = 8'h00;
    hold_b = 8'h00;
    @(negedge clk);
    check_reset("midreset_edge");
    in_valid = 1'b0;
    #2 rst_n = 1'b1;
    #1 check_reset("midreset_release");
    cycle("post_reset_idle", 1'b0, 8'hFF, 8'hFF, 8'h00, 8'h00);
    cycle("post_reset_first", 1'b1, 8'h96, 8'hF0, 8'h90, 8'h66);

    // Random stream with idle gaps.
    for (int i = 0; i < 1000; i++) begin
      rv = ($urandom_range(3) != 0);
      rx = 8'($urandom);
      ry = 8'($urandom);
      cycle("random", rv, rx, ry, rx & ry, rx ^ ry);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hal.md
Name: hal

Overview:
- First-stage half-adder logic (HAL) cell array for the modular adder/subtractor datapath.
- Per bit, computes the generate term a = x AND y and the half-sum/propagate term b = x XOR y, plus their complements not_a and not_b, for the later prefix/carry stages.
- Outputs are registered; one clock, asynchronous active-low reset.

Parameters:
- WIDTH, 1, number of independent bit-slices; each slice handles one bit of x and y.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  x/y are valid this cycle
- x  input  WIDTH  operand A bits
- y  input  WIDTH  operand B bits
- out_valid  output  1  a/b/not_a/not_b hold the result of a valid input
- not_b  output  WIDTH  bitwise complement of b
- b  output  WIDTH  half-sum/propagate: x XOR y
- not_a  output  WIDTH  bitwise complement of a
- a  output  WIDTH  generate/carry: x AND y

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous and active-low.
- Reset:
  - While rst_n = 0, independent of clk: a = 0, b = 0, not_a = all ones, not_b = all ones, out_valid = 0.
  - Release is synchronous to the next rising clk edge.
- Latency: 1 cycle. On the rising edge where in_valid = 1, the registers capture:
  - a = x & y, b = x ^ y
  - not_a = ~(x & y), not_b = ~(x ^ y)
  - out_valid = 1
- On an edge where in_valid = 0:
  - out_valid is registered to 0.
  - a, b, not_a and not_b hold their previous values, with no spurious toggling.
- Invariant, including during reset: not_a == ~a and not_b == ~b at every bit and every cycle.
- Bit-slices are fully independent, with no carry between bits.
- Back-to-back valid inputs give back-to-back valid outputs at full throughput. There is no backpressure.
- Reset asserted mid-stream: outputs go to reset values immediately and any in-flight result is discarded.
- No X propagation from the hold path. Outputs are defined from reset onward.
- Truth table per bit:
  - x=0, y=0 -> a=0 b=0 not_a=1 not_b=1
  - x=0, y=1 -> a=0 b=1 not_a=1 not_b=0
  - x=1, y=0 -> a=0 b=1 not_a=1 not_b=0
  - x=1, y=1 -> a=1 b=0 not_a=0 not_b=1

Decomposition:
- Shared package (modadd_pkg): default WIDTH constant, and a typedef for the per-bit result struct {a, not_a, b, not_b} reused by later stages.
- One sub-module is natural: hal_bit, a single combinational slice (x, y -> a, not_a, b, not_b).
- hal generates WIDTH instances of hal_bit and owns the output registers and the out_valid register.

Test Plan:
- Reset: hold rst_n=0 with x=1, y=1, in_valid=1 and clock running -> a=0, b=0, not_a=1, not_b=1, out_valid=0. Deassert asynchronously mid-cycle; outputs stay at reset values until the next edge.
- Exhaustive WIDTH=1: apply (x,y) = 00, 01, 10, 11 with in_valid=1, one per cycle. One cycle later, in order:
  - (a,b) = (0,0), (0,1), (0,1), (1,0)
  - complements inverted
  - out_valid=1 each cycle
- Hold: after x=1, y=1 valid, drive in_valid=0 with x=0, y=1 -> out_valid=0; a=1, b=0, not_a=0, not_b=1 unchanged.
- Multi-bit, WIDTH=4: x=4'b1100, y=4'b1010 -> a=4'b1000, b=4'b0110, not_a=4'b0111, not_b=4'b1001 after 1 cycle.
- Mid-stream reset: stream random valid inputs, pulse rst_n low between edges -> outputs jump to reset values immediately. Results resume 1 cycle after the first valid input following release.
- Random (1000 cycles, WIDTH=8): scoreboard checks a==x&y and b==x^y delayed by 1 cycle, and not_a==~a, not_b==~b every cycle.
